// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the second-order recurrence generator.
// Saturating arithmetic is selected at build time with SEQ_GEN_SAT_EN.
package seq_gen_pkg;

   typedef enum logic {
      StIdle,
      StRun
   } state_e;

   localparam logic MODE_ADD  = 1'b0;
   localparam logic MODE_PELL = 1'b1;

endpackage

// File: rtl/seq_gen_step.sv
// One recurrence step: term = a + b (additive) or 2a + b (Pell), with overflow detect.
// SEQ_GEN_SAT_EN defined: an overflowing term is clamped to all-ones.
module seq_gen_step
   import seq_gen_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic [WIDTH-1:0] term,
   output logic             ovf
);

   logic [WIDTH+1:0] sum;

   // Two guard bits hold the worst case 2a + b without wrapping.
   always_comb begin
      sum = {2'b00, b} + ((mode == MODE_PELL) ? {1'b0, a, 1'b0} : {2'b00, a});
      ovf = |sum[WIDTH+1:WIDTH];
`ifdef SEQ_GEN_SAT_EN
      term = ovf ? '1 : sum[WIDTH-1:0];
`else
      term = sum[WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/seq_recurrence_gen.sv
// Streams T(0)=seed0, T(1)=seed1, T(k)=f(T(k-1),T(k-2)) over valid/ready.
// SEQ_GEN_SAT_EN defined: overflowing terms saturate; otherwise the sequence truncates.
module seq_recurrence_gen
   import seq_gen_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] seed0,
   input  logic [WIDTH-1:0] seed1,
   input  logic             mode,
   input  logic [CNT_W-1:0] num_terms,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_index,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cur_q, cur_d;
   logic [WIDTH-1:0] nxt_q, nxt_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic             mode_q, mode_d;
   logic             nxt_ovf_q, nxt_ovf_d;
   logic             overflow_q, overflow_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] step_term;
   logic             step_ovf;
   logic             run, at_end, trunc, hs;

   seq_gen_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .a   (nxt_q),
      .b   (cur_q),
      .mode(mode_q),
      .term(step_term),
      .ovf (step_ovf)
   );

   always_comb begin
      run    = (state_q == StRun);
      at_end = (idx_q == num_q - CNT_W'(1));
`ifdef SEQ_GEN_SAT_EN
      trunc  = 1'b0;
`else
      // The upcoming term would not fit, so the current one ends the sequence.
      trunc  = nxt_ovf_q;
`endif
      out_valid = run;
      out_data  = run ? cur_q : '0;
      out_index = run ? idx_q : '0;
      out_last  = run & (at_end | trunc);
      hs        = out_valid & out_ready;
   end

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      nxt_d      = nxt_q;
      idx_d      = idx_q;
      num_d      = num_q;
      mode_d     = mode_q;
      nxt_ovf_d  = nxt_ovf_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               overflow_d = 1'b0;
               if (num_terms == '0) begin
                  done_d = 1'b1;
               end else begin
                  cur_d     = seed0;
                  nxt_d     = seed1;
                  idx_d     = '0;
                  num_d     = num_terms;
                  mode_d    = mode;
                  nxt_ovf_d = 1'b0;
                  state_d   = StRun;
               end
            end
         end
         StRun: begin
            if (hs) begin
               if (out_last) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
                  if (trunc && !at_end) overflow_d = 1'b1;
               end else begin
                  cur_d     = nxt_q;
                  nxt_d     = step_term;
                  idx_d     = idx_q + CNT_W'(1);
                  nxt_ovf_d = step_ovf;
                  // A saturated term is being presented now.
                  if (nxt_ovf_q) overflow_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cur_q      <= '0;
         nxt_q      <= '0;
         idx_q      <= '0;
         num_q      <= '0;
         mode_q     <= MODE_ADD;
         nxt_ovf_q  <= 1'b0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         nxt_q      <= nxt_d;
         idx_q      <= idx_d;
         num_q      <= num_d;
         mode_q     <= mode_d;
         nxt_ovf_q  <= nxt_ovf_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q == StRun);
   assign done     = done_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_recurrence_gen.sv
// Scoreboard bench for seq_recurrence_gen: a WIDTH=32 and a WIDTH=8 instance share stimulus.
// Expected terms follow SEQ_GEN_SAT_EN exactly as the design is built.
module tb_seq_recurrence_gen;

   typedef struct {
      logic [31:0] data;
      logic [15:0] idx;
      logic        last;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        start, sel;
   logic [31:0] seed0, seed1;
   logic        mode;
   logic [15:0] num_terms;
   logic        out_ready;

   logic        v32, l32, b32, dn32, o32;
   logic [31:0] d32;
   logic [15:0] i32;
   logic        v8, l8, b8, dn8, o8;
   logic [7:0]  d8;
   logic [15:0] i8;

   logic        obs_valid, obs_last, obs_busy, obs_done, obs_ovf;
   logic [31:0] obs_data;
   logic [15:0] obs_index;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clock = ~clock;

   seq_recurrence_gen #(.WIDTH(32), .CNT_W(16)) u_dut32 (
      .clock(clock), .reset(reset), .start(start & ~sel), .seed0(seed0), .seed1(seed1),
      .mode(mode), .num_terms(num_terms), .out_valid(v32), .out_ready(out_ready),
      .out_data(d32), .out_index(i32), .out_last(l32), .busy(b32), .done(dn32),
      .overflow(o32)
   );

   seq_recurrence_gen #(.WIDTH(8), .CNT_W(16)) u_dut8 (
      .clock(clock), .reset(reset), .start(start & sel), .seed0(seed0[7:0]),
      .seed1(seed1[7:0]), .mode(mode), .num_terms(num_terms), .out_valid(v8),
      .out_ready(out_ready), .out_data(d8), .out_index(i8), .out_last(l8), .busy(b8),
      .done(dn8), .overflow(o8)
   );

   assign obs_valid = sel ? v8 : v32;
   assign obs_data  = sel ? {24'd0, d8} : d32;
   assign obs_index = sel ? i8 : i32;
   assign obs_last  = sel ? l8 : l32;
   assign obs_busy  = sel ? b8 : b32;
   assign obs_done  = sel ? dn8 : dn32;
   assign obs_ovf   = sel ? o8 : o32;

   task automatic build_expected(input int w, input logic [31:0] a0, input logic [31:0] a1,
                                 input logic m, input logic [15:0] n, output bit ovf);
      longint mask, t;
      longint vals[$];
      exp_t   e;
      ovf  = 1'b0;
      mask = (longint'(1) << w) - 1;
      for (int k = 0; k < int'(n); k++) begin
         if (k == 0) t = longint'(a0);
         else if (k == 1) t = longint'(a1);
         else t = (m ? 2 * vals[k-1] : vals[k-1]) + vals[k-2];
         if (t > mask) begin
            ovf = 1'b1;
`ifdef SEQ_GEN_SAT_EN
            t = mask;
`else
            break;
`endif
         end
         vals.push_back(t);
      end
      for (int i = 0; i < vals.size(); i++) begin
         e.data = 32'(vals[i]);
         e.idx  = 16'(i);
         e.last = (i == vals.size() - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic run_seq(input string name, input bit s, input logic [31:0] a0,
                          input logic [31:0] a1, input logic m, input logic [15:0] n,
                          input int stall_at, input bit poke);
      int          cycles, stalls;
      bit          got_done, prev_stall, last_hs, exp_ovf;
      logic [31:0] held_d;
      logic [15:0] held_i;
      exp_t        e;
      build_expected(s ? 8 : 32, a0, a1, m, n, exp_ovf);
      sel = s; seed0 = a0; seed1 = a1; mode = m; num_terms = n; out_ready = 1'b1;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; seed0 = ~a0; seed1 = ~a1;
      cycles = 0; stalls = 0; got_done = 0; prev_stall = 0; last_hs = (n == 0);
      held_d = '0; held_i = '0;
      while (!got_done && cycles < 200) begin
         if (stall_at >= 0 && obs_valid && obs_index == 16'(stall_at) && stalls < 3) begin
            out_ready = 1'b0; start = poke; stalls++;
         end else begin
            out_ready = 1'b1; start = 1'b0;
         end
         @(negedge clock);
         if (prev_stall) begin
            n_checks++;
            if ({obs_valid, obs_data, obs_index} !== {1'b1, held_d, held_i}) begin
               n_fail++;
               $display("FAIL %s hold: got v=%0b d=%0d i=%0d, need v=1 d=%0d i=%0d", name,
                        obs_valid, obs_data, obs_index, held_d, held_i);
            end
         end
         prev_stall = obs_valid && !out_ready;
         held_d = obs_data; held_i = obs_index;
         if (obs_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s extra term: got d=%0d i=%0d, need none", name, obs_data,
                        obs_index);
            end else begin
               e = exp_q.pop_front();
               if ({obs_data, obs_index, obs_last} !== {e.data, e.idx, e.last}) begin
                  n_fail++;
                  $display("FAIL %s term: got d=%0d i=%0d last=%0b, need d=%0d i=%0d last=%0b",
                           name, obs_data, obs_index, obs_last, e.data, e.idx, e.last);
               end
            end
         end
         n_checks++;
         if (obs_done !== last_hs) begin
            n_fail++;
            $display("FAIL %s done timing: got %0b, need %0b", name, obs_done, last_hs);
         end
         got_done = (obs_done === 1'b1);
         last_hs  = obs_valid && out_ready && obs_last;
         @(posedge clock); #1;
         cycles++;
      end
      start = 1'b0; out_ready = 1'b1;
      n_checks++;
      if (!got_done) begin
         n_fail++;
         $display("FAIL %s timeout: got no done in 200 cycles, need done", name);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s missing terms: got %0d left, need 0", name, exp_q.size());
      end
      exp_q.delete();
      n_checks++;
      if ({obs_done, obs_busy, obs_valid, obs_ovf} !== {1'b0, 1'b0, 1'b0, exp_ovf}) begin
         n_fail++;
         $display("FAIL %s end state: got done=%0b busy=%0b valid=%0b ovf=%0b, need 0 0 0 %0b",
                  name, obs_done, obs_busy, obs_valid, obs_ovf, exp_ovf);
      end
   endtask

   task automatic check_zero(input string name);
      n_checks++;
      if ({obs_valid, obs_data, obs_index, obs_last, obs_busy, obs_done, obs_ovf} !== '0) begin
         n_fail++;
         $display("FAIL %s: got v=%0b d=%0d i=%0d l=%0b b=%0b dn=%0b o=%0b, need all 0", name,
                  obs_valid, obs_data, obs_index, obs_last, obs_busy, obs_done, obs_ovf);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; sel = 1'b0; seed0 = '0; seed1 = '0; mode = 1'b0;
      num_terms = '0; out_ready = 1'b1;
      #12;
      sel = 1'b0; #1 check_zero("reset_w32");
      sel = 1'b1; #1 check_zero("reset_w8");
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_fibonacci();
      run_seq("fib", 1'b0, 32'd0, 32'd1, 1'b0, 16'd10, -1, 1'b0);
   endtask

   task automatic test_lucas_pell();
      run_seq("lucas", 1'b0, 32'd2, 32'd1, 1'b0, 16'd6, -1, 1'b0);
      run_seq("pell", 1'b0, 32'd0, 32'd1, 1'b1, 16'd6, -1, 1'b0);
   endtask

   task automatic test_overflow();
      run_seq("ovf_fib8", 1'b1, 32'd0, 32'd1, 1'b0, 16'd20, -1, 1'b0);
      run_seq("ovf_pell8", 1'b1, 32'd3, 32'd7, 1'b1, 16'd12, -1, 1'b0);
      run_seq("after_ovf", 1'b1, 32'd1, 32'd1, 1'b0, 16'd5, -1, 1'b0);
   endtask

   task automatic test_backpressure();
      run_seq("backpressure", 1'b0, 32'd0, 32'd1, 1'b0, 16'd10, 4, 1'b1);
   endtask

   task automatic test_edge_counts();
      run_seq("n0", 1'b0, 32'd9, 32'd4, 1'b0, 16'd0, -1, 1'b0);
      run_seq("n1", 1'b0, 32'd7, 32'd3, 1'b0, 16'd1, -1, 1'b0);
      run_seq("n2", 1'b0, 32'd7, 32'd3, 1'b1, 16'd2, -1, 1'b0);
   endtask

   task automatic test_reset_mid();
      int guard;
      sel = 1'b0; seed0 = 32'd0; seed1 = 32'd1; mode = 1'b0; num_terms = 16'd10;
      out_ready = 1'b1; start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      guard = 0;
      @(negedge clock);
      while (!(obs_valid && obs_index == 16'd5) && guard < 50) begin
         @(negedge clock); guard++;
      end
      n_checks++;
      if (guard >= 50) begin
         n_fail++;
         $display("FAIL reset_mid reach: got index %0d, need 5", obs_index);
      end
      reset = 1'b1; #1;
      check_zero("reset_mid_async");
      @(posedge clock); #1;
      check_zero("reset_mid_no_done");
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
      run_seq("restart", 1'b0, 32'd0, 32'd1, 1'b0, 16'd4, -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_fibonacci();
      test_lucas_pell();
      test_overflow();
      test_backpressure();
      test_edge_counts();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_recurrence_gen.md
Name: seq_recurrence_gen

Overview:
- Parametrised second-order recurrence generator; successor to the free-running Fibonacci counter.
- Produces a bounded, programmable sequence T(0)=seed0, T(1)=seed1, T(k)=f(T(k-1),T(k-2)), selected by mode.
- Streams terms over a valid/ready interface with index, last and overflow reporting.
- Sits as a test-pattern and number-sequence source feeding downstream stream consumers.

Parameters:
- WIDTH, 32, term data width in bits (>=4)
- CNT_W, 16, width of the term count and index

Ports:
- clock      input   1      system clock
- reset      input   1      asynchronous, active-high reset
- start      input   1      single-cycle request; samples seed0, seed1, mode, num_terms
- seed0      input   WIDTH  T(0)
- seed1      input   WIDTH  T(1)
- mode       input   1      0 = additive (T=a+b); 1 = Pell (T=2a+b, where a=T(k-1), b=T(k-2))
- num_terms  input   CNT_W  number of terms to emit
- out_valid  output  1      current term valid
- out_ready  input   1      consumer accepts the term
- out_data   output  WIDTH  current term
- out_index  output  CNT_W  index k of the current term
- out_last   output  1      current term is the final one
- busy       output  1      sequence in progress
- done       output  1      one-cycle pulse when a sequence completes
- overflow   output  1      sticky flag: a term exceeded WIDTH; cleared on start

Behaviour:
- Reset: out_valid, out_data, out_index, out_last, busy, done and overflow are all 0. FSM goes to IDLE.
- Reset taking effect mid-sequence aborts the sequence immediately; no done pulse is produced.
- FSM states: IDLE, RUN.
- IDLE, start=1, num_terms=0: stay in IDLE, done=1 next cycle, no term emitted, overflow cleared.
- IDLE, start=1, num_terms>0, on the next edge:
  - cur<=seed0, nxt<=seed1, index<=0, overflow<=0, enter RUN.
  - out_valid=1 from that cycle (1-cycle start-to-valid latency).
- RUN, combinational outputs:
  - out_data=cur, out_index=index.
  - out_last = (index==num_terms-1) OR (nxt_ovf AND SAT disabled).
- RUN, handshake = out_valid & out_ready:
  - If out_last: go to IDLE, out_valid=0, done=1 for one cycle.
  - Otherwise: cur<=nxt, nxt<=f(nxt,cur), index<=index+1, nxt_ovf<=overflow of that computation.
- Without a handshake, every output holds stable; valid is never retracted.
- start while busy is ignored.
- Arithmetic: computed at WIDTH+2 bits; overflow when any bit above WIDTH-1 is set; overflow flag is set when that term is presented.
- num_terms=1: emit seed0 with out_last=1.
- num_terms=2: emit seed0, then seed1 with last.
- Throughput: one term per cycle while out_ready=1.
- overflow and busy (=state==RUN) are registered.

Optional Feature:
- Macro: SEQ_GEN_SAT_EN.
- Defined: an overflowing term is clamped to all-ones. Clamped values feed later computations, so subsequent terms also clamp. The sequence always runs the full num_terms. overflow is still set.
- Undefined: the sequence truncates; the last valid term before the overflowing one carries out_last. done pulses and overflow=1.

Decomposition:
- Package seq_gen_pkg:
  - state enum {IDLE, RUN}
  - mode constants MODE_ADD=1'b0, MODE_PELL=1'b1
- Sub-module seq_gen_step (combinational):
  - inputs a, b, mode
  - outputs next term (saturated when SEQ_GEN_SAT_EN is defined) and ovf
  - parametrised by WIDTH

Test Plan:
- Fibonacci, WIDTH=32, seeds 0,1, mode 0, num_terms=10, out_ready=1 -> 0,1,1,2,3,5,8,13,21,34 at indices 0..9; last on 34; done one cycle later; overflow=0.
- Lucas and Pell: seeds 2,1 mode 0 n=6 -> 2,1,3,4,7,11. Seeds 0,1 mode 1 n=6 -> 0,1,2,5,12,29.
- Overflow, WIDTH=8, seeds 0,1, mode 0, n=20:
  - Macro undefined -> terms to 233 (index 13) with last, overflow=1.
  - SEQ_GEN_SAT_EN -> index 14..19 = 255, last at 19, overflow=1.
- Backpressure: out_ready low for 3 cycles at index 4 -> data 3, index 4 held stable, no skip or duplicate; start pulsed during RUN is ignored.
- Edge counts: n=0 -> done pulse, no valid. n=1 -> seed0 with last.
- Reset asserted at index 5 -> all outputs 0 the same cycle; a later start begins cleanly at index 0.
